motion_compensation_stream: RTL and testbench

MOTION_COMPENSATION_STREAM -- requirements
Module: motion_compensation_stream

---
 rtl/motion_compensation_stream_pkg.sv | 30 +++
 rtl/motion_compensation_stream_coord_clamp.sv | 24 ++
 rtl/motion_compensation_stream.sv | 226 ++++++++++++++++++++++
 tb/tb_motion_compensation_stream.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motion_compensation_stream_pkg.sv
// mc_pkg: shared types and width helpers for motion_compensation_stream.
//   mc_state_e - block-processing FSM states
//   res_w()    - residual width (one sign bit over a pixel)
//   sad_w()    - SAD accumulator width for an MB x MB block
//   max3()     - widest of three coordinate widths
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_EMIT,
    ST_DONE
  } mc_state_e;

  function automatic int res_w(input int pixel_width);
    return pixel_width + 1;
  endfunction

  function automatic int sad_w(input int pixel_width, input int mb_size);
    return pixel_width + 2 * $clog2(mb_size);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/motion_compensation_stream_coord_clamp.sv
// mc_coord_clamp: clamps a two's-complement coordinate sum into [0, MAX_VAL].
//   sum   in  SUM_W  two's-complement coordinate (origin + MV + offset)
//   coord out OUT_W  clamped unsigned coordinate (edge replication)
module mc_coord_clamp #(
  parameter int SUM_W   = 10,
  parameter int OUT_W   = 3,
  parameter int MAX_VAL = 7
) (
  input  logic [SUM_W-1:0] sum,
  output logic [OUT_W-1:0] coord
);

  localparam logic [SUM_W-1:0] MAX_S = SUM_W'(MAX_VAL);

  always_comb begin
    coord = sum[OUT_W-1:0];
    if (sum[SUM_W-1]) begin
      coord = '0;
    end else if ($signed(sum) > $signed(MAX_S)) begin
      coord = MAX_S[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/motion_compensation_stream.sv
// motion_compensation_stream: row-by-row motion-compensated residual engine.
// Fetches each predicted row from an external reference frame (1-cycle read
// latency), subtracts it from the current block and streams signed residual
// rows with valid/ready handshake, accumulating the block SAD.
//   start/mb_x/mb_y/mv_x/mv_y/curr_mb  block request, sampled when idle
//   ref_rd_en/ref_rd_x/ref_rd_y        reference read request
//   ref_rd_data                        read data, one cycle after request
//   res_row/res_row_idx/res_valid      residual row output (res_ready input)
//   busy/done/sad                      status, completion pulse, block SAD
module motion_compensation_stream
  import mc_pkg::*;
#(
  parameter int MB_SIZE     = 4,
  parameter int PIXEL_WIDTH = 8,
  parameter int FRAME_W     = 8,
  parameter int FRAME_H     = 8,
  parameter int MV_WIDTH    = 6
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic [$clog2(FRAME_W)-1:0]                  mb_x,
  input  logic [$clog2(FRAME_H)-1:0]                  mb_y,
  input  logic [MV_WIDTH-1:0]                         mv_x,
  input  logic [MV_WIDTH-1:0]                         mv_y,
  input  logic [MB_SIZE*MB_SIZE*PIXEL_WIDTH-1:0]      curr_mb,
  output logic                                        ref_rd_en,
  output logic [$clog2(FRAME_W)-1:0]                  ref_rd_x,
  output logic [$clog2(FRAME_H)-1:0]                  ref_rd_y,
  input  logic [PIXEL_WIDTH-1:0]                      ref_rd_data,
  output logic [MB_SIZE*res_w(PIXEL_WIDTH)-1:0]       res_row,
  output logic [$clog2(MB_SIZE)-1:0]                  res_row_idx,
  output logic                                        res_valid,
  input  logic                                        res_ready,
  output logic                                        busy,
  output logic                                        done,
  output logic [sad_w(PIXEL_WIDTH, MB_SIZE)-1:0]      sad
);

  localparam int XW    = $clog2(FRAME_W);
  localparam int YW    = $clog2(FRAME_H);
  localparam int RW    = $clog2(MB_SIZE);
  localparam int RESW  = res_w(PIXEL_WIDTH);
  localparam int SADW  = sad_w(PIXEL_WIDTH, MB_SIZE);
  localparam int AW    = max3(XW, YW, RW);
  // Wide enough for unsigned origin + signed MV + unsigned offset without overflow.
  localparam int SUM_W = MV_WIDTH + AW + 2;
  localparam logic [RW-1:0] LAST = RW'(MB_SIZE - 1);

  mc_state_e state_q, state_d;

  logic [XW-1:0]          mb_x_q, mb_x_d;
  logic [YW-1:0]          mb_y_q, mb_y_d;
  logic [MV_WIDTH-1:0]    mv_x_q, mv_x_d;
  logic [MV_WIDTH-1:0]    mv_y_q, mv_y_d;
  logic [PIXEL_WIDTH-1:0] curr_q [MB_SIZE][MB_SIZE];
  logic [PIXEL_WIDTH-1:0] curr_d [MB_SIZE][MB_SIZE];
  logic [RW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic                   cap_en_q, cap_en_d;
  logic [RW-1:0]          cap_col_q, cap_col_d;
  logic [RESW-1:0]        res_q [MB_SIZE];
  logic [RESW-1:0]        res_d [MB_SIZE];
  logic [SADW-1:0]        sad_q, sad_d;

  logic [SUM_W-1:0]       sum_x, sum_y;
  logic [XW-1:0]          clamp_x;
  logic [YW-1:0]          clamp_y;
  logic [RESW-1:0]        diff;
  logic [RESW-1:0]        abs_diff;

  // Address generation: column offset for x, row offset for y.
  always_comb begin
    sum_x = {{(SUM_W-XW){1'b0}}, mb_x_q}
          + {{(SUM_W-MV_WIDTH){mv_x_q[MV_WIDTH-1]}}, mv_x_q}
          + {{(SUM_W-RW){1'b0}}, col_q};
    sum_y = {{(SUM_W-YW){1'b0}}, mb_y_q}
          + {{(SUM_W-MV_WIDTH){mv_y_q[MV_WIDTH-1]}}, mv_y_q}
          + {{(SUM_W-RW){1'b0}}, row_q};
  end

  mc_coord_clamp #(
    .SUM_W  (SUM_W),
    .OUT_W  (XW),
    .MAX_VAL(FRAME_W - 1)
  ) u_clamp_x (
    .sum  (sum_x),
    .coord(clamp_x)
  );

  mc_coord_clamp #(
    .SUM_W  (SUM_W),
    .OUT_W  (YW),
    .MAX_VAL(FRAME_H - 1)
  ) u_clamp_y (
    .sum  (sum_y),
    .coord(clamp_y)
  );

  // Residual of the pixel whose reference data arrives this cycle.
  always_comb begin
    diff     = {1'b0, curr_q[row_q][cap_col_q]} - {1'b0, ref_rd_data};
    abs_diff = diff[RESW-1] ? (~diff + 1'b1) : diff;
  end

  always_comb begin
    state_d   = state_q;
    mb_x_d    = mb_x_q;
    mb_y_d    = mb_y_q;
    mv_x_d    = mv_x_q;
    mv_y_d    = mv_y_q;
    curr_d    = curr_q;
    col_d     = col_q;
    row_d     = row_q;
    res_d     = res_q;
    sad_d     = sad_q;
    ref_rd_en = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    // Read data lags the request by one cycle, so capture runs one column
    // behind the address counter (the last column lands in DRAIN).
    if (cap_en_q) begin
      res_d[cap_col_q] = diff;
      sad_d            = sad_q + SADW'(abs_diff);
    end

    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = ST_FETCH;
          mb_x_d  = mb_x;
          mb_y_d  = mb_y;
          mv_x_d  = mv_x;
          mv_y_d  = mv_y;
          col_d   = '0;
          row_d   = '0;
          sad_d   = '0;
          for (int unsigned r = 0; r < MB_SIZE; r++) begin
            for (int unsigned c = 0; c < MB_SIZE; c++) begin
              curr_d[r][c] = curr_mb[(r*MB_SIZE + c)*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
          end
        end
      end
      ST_FETCH: begin
        ref_rd_en = 1'b1;
        if (col_q == LAST) begin
          col_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          if (row_q == LAST) begin
            state_d = ST_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    cap_en_d  = ref_rd_en;
    cap_col_d = col_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      mb_x_q    <= '0;
      mb_y_q    <= '0;
      mv_x_q    <= '0;
      mv_y_q    <= '0;
      curr_q    <= '{default: '0};
      col_q     <= '0;
      row_q     <= '0;
      cap_en_q  <= 1'b0;
      cap_col_q <= '0;
      res_q     <= '{default: '0};
      sad_q     <= '0;
    end else begin
      state_q   <= state_d;
      mb_x_q    <= mb_x_d;
      mb_y_q    <= mb_y_d;
      mv_x_q    <= mv_x_d;
      mv_y_q    <= mv_y_d;
      curr_q    <= curr_d;
      col_q     <= col_d;
      row_q     <= row_d;
      cap_en_q  <= cap_en_d;
      cap_col_q <= cap_col_d;
      res_q     <= res_d;
      sad_q     <= sad_d;
    end
  end

  always_comb begin
    res_row = '0;
    for (int unsigned c = 0; c < MB_SIZE; c++) begin
      res_row[c*RESW +: RESW] = res_q[c];
    end
    res_row_idx = row_q;
    sad         = sad_q;
    ref_rd_x    = ref_rd_en ? clamp_x : '0;
    ref_rd_y    = ref_rd_en ? clamp_y : '0;
  end

endmodule

// File: tb/tb_motion_compensation_stream.sv
// Bench for motion_compensation_stream: stimulus pushes expected residual rows
// and block SAD into queues; a monitor pops and compares on each output event.
module tb_motion_compensation_stream;

  localparam int MB   = 4;
  localparam int PW   = 8;
  localparam int FW   = 8;
  localparam int FH   = 8;
  localparam int MVW  = 6;
  localparam int RESW = PW + 1;
  localparam int SADW = PW + 2 * $clog2(MB);

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic [2:0]               mb_x, mb_y;
  logic [MVW-1:0]           mv_x, mv_y;
  logic [MB*MB*PW-1:0]      curr_mb;
  logic                     ref_rd_en;
  logic [2:0]               ref_rd_x, ref_rd_y;
  logic [PW-1:0]            ref_rd_data;
  logic [MB*RESW-1:0]       res_row;
  logic [1:0]               res_row_idx;
  logic                     res_valid;
  logic                     res_ready;
  logic                     busy;
  logic                     done;
  logic [SADW-1:0]          sad;

  always #5 clk = ~clk;

  motion_compensation_stream #(
    .MB_SIZE    (MB),
    .PIXEL_WIDTH(PW),
    .FRAME_W    (FW),
    .FRAME_H    (FH),
    .MV_WIDTH   (MVW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mb_x       (mb_x),
    .mb_y       (mb_y),
    .mv_x       (mv_x),
    .mv_y       (mv_y),
    .curr_mb    (curr_mb),
    .ref_rd_en  (ref_rd_en),
    .ref_rd_x   (ref_rd_x),
    .ref_rd_y   (ref_rd_y),
    .ref_rd_data(ref_rd_data),
    .res_row    (res_row),
    .res_row_idx(res_row_idx),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .busy       (busy),
    .done       (done),
    .sad        (sad)
  );

  // Reference frame with one-cycle read latency.
  logic [PW-1:0] refm [FH][FW];
  always @(posedge clk) begin
    if (ref_rd_en) ref_rd_data <= refm[ref_rd_y][ref_rd_x];
  end

  typedef struct {
    logic [MB*RESW-1:0] row;
    logic [1:0]         idx;
  } exp_row_t;

  exp_row_t        exp_rows[$];
  logic [SADW-1:0] exp_sad[$];
  int n_total = 0;
  int n_bad   = 0;
  int ready_mode = 0;

  // Consumer: 0 = always ready, 1 = random, 2 = stall 5 cycles on row 1.
  initial begin
    int hold_cnt;
    hold_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!busy) hold_cnt = 0;
      case (ready_mode)
        0: res_ready = 1'b1;
        1: res_ready = 1'($urandom_range(0, 1));
        default: begin
          if (res_valid && res_row_idx == 2'd1 && hold_cnt < 5) begin
            res_ready = 1'b0;
            hold_cnt++;
          end else begin
            res_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: every presented row must equal the queue head (also proves it
  // stays stable while stalled); pop on transfer. done carries the SAD.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (res_valid) begin
        n_total++;
        if (exp_rows.size() == 0) begin
          n_bad++;
          $display("FAIL res_unexpected: got row=%h idx=%0d, required no valid row", res_row, res_row_idx);
        end else begin
          if (res_row !== exp_rows[0].row || res_row_idx !== exp_rows[0].idx || ref_rd_en !== 1'b0) begin
            n_bad++;
            $display("FAIL res_row: got row=%h idx=%0d rd_en=%0b, required row=%h idx=%0d rd_en=0",
                     res_row, res_row_idx, ref_rd_en, exp_rows[0].row, exp_rows[0].idx);
          end
          if (res_ready) void'(exp_rows.pop_front());
        end
      end
      if (done) begin
        n_total++;
        if (exp_sad.size() == 0) begin
          n_bad++;
          $display("FAIL done_unexpected: got done with sad=%0d, required no done", sad);
        end else begin
          if (sad !== exp_sad[0] || exp_rows.size() != 0) begin
            n_bad++;
            $display("FAIL sad_done: got sad=%0d rows_left=%0d, required sad=%0d rows_left=0",
                     sad, exp_rows.size(), exp_sad[0]);
          end
          void'(exp_sad.pop_front());
        end
      end
    end
  end

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic set_ref(input int mode);
    for (int y = 0; y < FH; y++) begin
      for (int x = 0; x < FW; x++) begin
        case (mode)
          0: refm[y][x] = PW'(8 * y + x);
          1: refm[y][x] = 8'd255;
          default: refm[y][x] = PW'($urandom_range(0, 255));
        endcase
      end
    end
  endtask

  task automatic check_reset_state(input string name);
    n_total++;
    if ({res_valid, done, busy, ref_rd_en, res_row, res_row_idx, sad, ref_rd_x, ref_rd_y} !== '0) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b done=%0b busy=%0b rd_en=%0b row=%h idx=%0d sad=%0d x=%0d y=%0d, required all zero",
               name, res_valid, done, busy, ref_rd_en, res_row, res_row_idx, sad, ref_rd_x, ref_rd_y);
    end
  endtask

  // Issues one block; abort=1 pulls reset during row 2 fetch instead of completing.
  task automatic run_block(input int bmbx, input int bmby, input int bmvx, input int bmvy,
                           input logic [MB*MB*PW-1:0] bcurr, input bit abort);
    int s, d, px, py, cyc, lat, nrd;
    bit fin;
    logic [MB*RESW-1:0] row;
    s = 0;
    for (int r = 0; r < MB; r++) begin
      row = '0;
      for (int c = 0; c < MB; c++) begin
        py = clampi(bmby + bmvy + r, FH - 1);
        px = clampi(bmbx + bmvx + c, FW - 1);
        d  = int'(bcurr[(r*MB + c)*PW +: PW]) - int'(refm[py][px]);
        row[c*RESW +: RESW] = d[RESW-1:0];
        s += (d < 0) ? -d : d;
      end
      exp_rows.push_back('{row, 2'(r)});
    end
    exp_sad.push_back(SADW'(s));

    mb_x    = bmbx[2:0];
    mb_y    = bmby[2:0];
    mv_x    = bmvx[MVW-1:0];
    mv_y    = bmvy[MVW-1:0];
    curr_mb = bcurr;
    start   = 1'b1;
    cyc = 0; lat = -1; nrd = 0; fin = 1'b0;

    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      // Decoy requests while busy must be ignored.
      if (busy && !done && $urandom_range(0, 3) == 0) begin
        start   = 1'b1;
        mb_x    = 3'($urandom);
        mb_y    = 3'($urandom);
        mv_x    = MVW'($urandom);
        mv_y    = MVW'($urandom);
        curr_mb = {$urandom, $urandom, $urandom, $urandom};
      end
      if (ref_rd_en) nrd++;
      if (res_valid && lat < 0) begin
        lat = cyc;
        n_total++;
        if (lat != MB + 2) begin
          n_bad++;
          $display("FAIL first_valid_latency: got %0d cycles, required %0d", lat, MB + 2);
        end
      end
      if (abort && ref_rd_en && res_row_idx == 2'd2) begin
        reset = 1'b0;
        start = 1'b0;
        exp_rows.delete();
        exp_sad.delete();
        @(negedge clk);
        check_reset_state("reset_mid_block");
        reset = 1'b1;
        return;
      end
      if (done) begin
        fin = 1'b1;
        n_total++;
        if (nrd != MB * MB) begin
          n_bad++;
          $display("FAIL read_count: got %0d reads, required %0d", nrd, MB * MB);
        end
        // Request in the DONE cycle must be ignored.
        start   = 1'b1;
        mb_x    = 3'($urandom);
        mv_x    = MVW'($urandom);
        curr_mb = {$urandom, $urandom, $urandom, $urandom};
      end
    end

    if (!fin) begin
      n_total++;
      n_bad++;
      $display("FAIL block_timeout: got no done within %0d cycles, required done", cyc);
      return;
    end
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if (sad !== SADW'(s) || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL sad_hold: got sad=%0d busy=%0b, required sad=%0d busy=0", sad, busy, s);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MB*MB*PW-1:0] curr100;
    curr100 = {(MB*MB){8'd100}};
    reset   = 1'b0;
    start   = 1'b0;
    mb_x    = '0;
    mb_y    = '0;
    mv_x    = '0;
    mv_y    = '0;
    curr_mb = '0;
    set_ref(0);
    repeat (3) @(negedge clk);
    check_reset_state("reset_init");
    reset = 1'b1;

    run_block(0, 0, 1, 1, curr100, 1'b0);
    run_block(4, 4, 3, 3, curr100, 1'b0);
    run_block(0, 0, -2, -2, curr100, 1'b0);
    set_ref(1);
    run_block(0, 0, 0, 0, '0, 1'b0);
    set_ref(0);
    ready_mode = 2;
    run_block(0, 0, 1, 1, curr100, 1'b0);
    ready_mode = 0;
    run_block(0, 0, 1, 1, curr100, 1'b1);
    run_block(0, 0, 1, 1, curr100, 1'b0);

    for (int i = 0; i < 20; i++) begin
      set_ref(2);
      ready_mode = $urandom_range(0, 1);
      run_block($urandom_range(0, FW - 1), $urandom_range(0, FH - 1),
                int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32,
                {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    end

    ready_mode = 0;
    repeat (3) @(negedge clk);
    n_total++;
    if (exp_rows.size() != 0 || exp_sad.size() != 0) begin
      n_bad++;
      $display("FAIL queue_leftover: got rows=%0d sads=%0d, required 0 and 0", exp_rows.size(), exp_sad.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
